noc_local_depacketizer: RTL and testbench

- Sits on the local output port of one mesh router (one instance per node, 16 in the 4x4 mesh).
- Consumes the 8-bit flit stream the router ejects for its node and reassembles each 7-flit packet (1 head, 5 body, 1 tail) into a 32-bit word.
- Delivers the word to the node over a valid/ready interface.
- Drives the router's ON_OFF back-pressure input, checks destination coordinates and flit ordering, and reports protocol errors.

---
 rtl/noc_local_depacketizer.sv | 153 +++++++++++++++
 tb/tb_noc_local_depacketizer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_depacketizer.sv
// Local-port depacketizer for one mesh node: reassembles head/body/tail flit
// packets into a payload word, applies ON_OFF back-pressure through a one-flit
// skid, checks destination coordinates and flit ordering, and counts packets.
module noc_local_depacketizer #(
  parameter int MY_X       = 3,
  parameter int MY_Y       = 3,
  parameter int BODY_FLITS = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                flit_in,
  input  logic                      flit_valid,
  output logic                      on_off,
  output logic [6*BODY_FLITS+1:0]   pkt_data,
  output logic                      pkt_dest_err,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [15:0]               pkt_count,
  output logic                      err_proto,
  output logic                      err_overflow,
  input  logic                      err_clr
);

  localparam int AW = 6 * BODY_FLITS;
  localparam int PW = AW + 2;
  localparam int CW = $clog2(BODY_FLITS + 1);

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_TAIL} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   asm_q;
  logic            dest_err_q;
  logic [7:0]      skid_q;
  logic            skid_full_q;
  logic            skid_full_d;
  logic            on_off_q;
  logic [PW-1:0]   pkt_data_q;
  logic            pkt_dest_err_q;
  logic            pkt_valid_q;
  logic [15:0]     pkt_count_q;
  logic            err_proto_q;
  logic            err_overflow_q;

  logic            cur_vld;
  logic [7:0]      cur_flit;
  logic [1:0]      cur_type;
  logic            stall;
  logic            proc;
  logic            overflow;
  logic            proto_evt;
  logic            head_dest_err;

  // Select the flit to work on this cycle and decode stall/error events.
  always_comb begin
    cur_vld       = skid_full_q | flit_valid;
    cur_flit      = skid_full_q ? skid_q : flit_in;
    cur_type      = cur_flit[1:0];
    // Only a tail can complete a packet, so only a tail waits on the consumer.
    stall         = cur_vld && (cur_type == T_TAIL) && pkt_valid_q && !pkt_ready;
    proc          = cur_vld && !stall;
    // The skid is full exactly when a flit had to wait this cycle.
    skid_full_d   = stall;
    overflow      = flit_valid && skid_full_q;
    head_dest_err = (cur_flit[7:5] != MY_X[2:0]) || (cur_flit[4:2] != MY_Y[2:0]);
    proto_evt     = 1'b0;
    if (proc) begin
      case (cur_type)
        T_HEAD:  proto_evt = (state_q != S_IDLE);
        T_BODY:  proto_evt = (state_q != S_BODY);
        T_TAIL:  proto_evt = (state_q != S_TAIL);
        default: proto_evt = 1'b1;
      endcase
    end
  end

  // Reassembly FSM, skid, output register, counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      asm_q          <= '0;
      dest_err_q     <= 1'b0;
      skid_q         <= '0;
      skid_full_q    <= 1'b0;
      on_off_q       <= 1'b1;
      pkt_data_q     <= '0;
      pkt_dest_err_q <= 1'b0;
      pkt_valid_q    <= 1'b0;
      pkt_count_q    <= '0;
      err_proto_q    <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      on_off_q    <= !skid_full_d;
      if (stall && !skid_full_q) skid_q <= flit_in;

      if (pkt_valid_q && pkt_ready) pkt_valid_q <= 1'b0;

      if (proc) begin
        case (cur_type)
          T_HEAD: begin
            // A head always (re)starts a packet, aborting any partial one.
            dest_err_q <= head_dest_err;
            asm_q      <= '0;
            cnt_q      <= '0;
            state_q    <= S_BODY;
          end
          T_BODY: begin
            if (state_q == S_BODY) begin
              for (int i = 0; i < BODY_FLITS; i++) begin
                if (cnt_q == CW'(i)) asm_q[AW-6-6*i +: 6] <= cur_flit[7:2];
              end
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q == CW'(BODY_FLITS - 1)) state_q <= S_TAIL;
            end else begin
              state_q <= S_IDLE;
            end
          end
          T_TAIL: begin
            if (state_q == S_TAIL) begin
              pkt_data_q     <= {cur_flit[7:6], asm_q};
              pkt_dest_err_q <= dest_err_q;
              pkt_valid_q    <= 1'b1;
              pkt_count_q    <= pkt_count_q + 16'd1;
            end
            state_q <= S_IDLE;
          end
          default: ;
        endcase
      end

      // A new error in the same cycle as a clear keeps the flag set.
      if (proto_evt)    err_proto_q    <= 1'b1;
      else if (err_clr) err_proto_q    <= 1'b0;
      if (overflow)     err_overflow_q <= 1'b1;
      else if (err_clr) err_overflow_q <= 1'b0;
    end
  end

  assign on_off       = on_off_q;
  assign pkt_data     = pkt_data_q;
  assign pkt_dest_err = pkt_dest_err_q;
  assign pkt_valid    = pkt_valid_q;
  assign pkt_count    = pkt_count_q;
  assign err_proto    = err_proto_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_noc_local_depacketizer.sv
// Directed bench for noc_local_depacketizer: two instances share stimulus,
// one at node (3,3) and one at node (1,2), to cover destination matching.
module tb_noc_local_depacketizer;

  logic        clk;
  logic        rst;
  logic [7:0]  flit_in;
  logic        flit_valid;
  logic        pkt_ready;
  logic        err_clr;

  logic        on_off_a,   on_off_b;
  logic [31:0] data_a,     data_b;
  logic        derr_a,     derr_b;
  logic        valid_a,    valid_b;
  logic [15:0] count_a,    count_b;
  logic        eproto_a,   eproto_b;
  logic        eovf_a,     eovf_b;

  int checks = 0;
  int errors = 0;

  noc_local_depacketizer #(.MY_X(3), .MY_Y(3), .BODY_FLITS(5)) dut_a (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .on_off(on_off_a), .pkt_data(data_a), .pkt_dest_err(derr_a),
    .pkt_valid(valid_a), .pkt_ready(pkt_ready), .pkt_count(count_a),
    .err_proto(eproto_a), .err_overflow(eovf_a), .err_clr(err_clr)
  );

  noc_local_depacketizer #(.MY_X(1), .MY_Y(2), .BODY_FLITS(5)) dut_b (
    .clk(clk), .rst(rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .on_off(on_off_b), .pkt_data(data_b), .pkt_dest_err(derr_b),
    .pkt_valid(valid_b), .pkt_ready(pkt_ready), .pkt_count(count_b),
    .err_proto(eproto_b), .err_overflow(eovf_b), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] f);
    flit_in    = f;
    flit_valid = 1'b1;
    tick();
    flit_valid = 1'b0;
    flit_in    = 8'h00;
  endtask

  task automatic send_front();
    send(8'h6C);
    send(8'h0D);
    for (int i = 0; i < 4; i++) send(8'hFD);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    flit_valid = 1'b0; flit_in = 8'h00; pkt_ready = 1'b1; err_clr = 1'b0;
    do_reset();
    checks++; if (on_off_a !== 1'b1) begin errors++; $display("FAIL reset_on_off: got %b exp 1", on_off_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_a); end
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL reset_data: got %h exp 00000000", data_a); end
    checks++; if (count_a !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count_a); end
    checks++; if ({derr_a, eproto_a, eovf_a} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {derr_a, eproto_a, eovf_a}); end
  endtask

  task automatic test_nominal();
    do_reset();
    pkt_ready = 1'b1;
    send_front();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL nom_valid_before_tail: got %b exp 0", valid_a); end
    send(8'h82);
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL nom_valid: got %b exp 1", valid_a); end
    checks++; if (data_a !== 32'h83FFFFFF) begin errors++; $display("FAIL nom_data: got %h exp 83ffffff", data_a); end
    checks++; if (derr_a !== 1'b0) begin errors++; $display("FAIL nom_dest_err: got %b exp 0", derr_a); end
    checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL nom_count: got %0d exp 1", count_a); end
    checks++; if (on_off_a !== 1'b1) begin errors++; $display("FAIL nom_on_off: got %b exp 1", on_off_a); end
    tick();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL nom_valid_one_cycle: got %b exp 0", valid_a); end
  endtask

  task automatic test_dest_mismatch();
    do_reset();
    pkt_ready = 1'b1;
    send_front();
    send(8'h82);
    checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL dest_valid: got %b exp 1", valid_b); end
    checks++; if (data_b !== 32'h83FFFFFF) begin errors++; $display("FAIL dest_data: got %h exp 83ffffff", data_b); end
    checks++; if (derr_b !== 1'b1) begin errors++; $display("FAIL dest_err: got %b exp 1", derr_b); end
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    pkt_ready = 1'b0;
    send_front();
    send(8'h82);
    tick();
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL bp_held_valid: got %b exp 1", valid_a); end
    send_front();
    send(8'h42);
    checks++; if (on_off_a !== 1'b0) begin errors++; $display("FAIL bp_on_off_low: got %b exp 0", on_off_a); end
    checks++; if (data_a !== 32'h83FFFFFF) begin errors++; $display("FAIL bp_held_data: got %h exp 83ffffff", data_a); end
    checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL bp_count_held: got %0d exp 1", count_a); end
    tick();
    checks++; if (on_off_a !== 1'b0) begin errors++; $display("FAIL bp_on_off_stays_low: got %b exp 0", on_off_a); end
    pkt_ready = 1'b1;
    tick();
    checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL bp_b2b_valid: got %b exp 1", valid_a); end
    checks++; if (data_a !== 32'h43FFFFFF) begin errors++; $display("FAIL bp_second_data: got %h exp 43ffffff", data_a); end
    checks++; if (count_a !== 16'd2) begin errors++; $display("FAIL bp_count: got %0d exp 2", count_a); end
    checks++; if (on_off_a !== 1'b1) begin errors++; $display("FAIL bp_on_off_back: got %b exp 1", on_off_a); end
    tick();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b exp 0", valid_a); end
  endtask

  task automatic test_overflow();
    do_reset();
    pkt_ready = 1'b0;
    send_front();
    send(8'h82);
    send_front();
    send(8'h42);
    send(8'hFD);
    checks++; if (eovf_a !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", eovf_a); end
    checks++; if (eproto_a !== 1'b0) begin errors++; $display("FAIL ovf_no_proto: got %b exp 0", eproto_a); end
    err_clr = 1'b1;
    send(8'hFD);
    checks++; if (eovf_a !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b exp 1", eovf_a); end
    tick();
    err_clr = 1'b0;
    checks++; if (eovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", eovf_a); end
    pkt_ready = 1'b1;
    tick();
    checks++; if (data_a !== 32'h43FFFFFF) begin errors++; $display("FAIL ovf_skid_kept: got %h exp 43ffffff", data_a); end
    tick();
    checks++; if (eovf_a !== 1'b0) begin errors++; $display("FAIL ovf_stays_clear: got %b exp 0", eovf_a); end
  endtask

  task automatic test_protocol();
    do_reset();
    pkt_ready = 1'b1;
    send(8'hFD);
    checks++; if (eproto_a !== 1'b1) begin errors++; $display("FAIL proto_body_idle: got %b exp 1", eproto_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL proto_body_idle_nopkt: got %b exp 0", valid_a); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checks++; if (eproto_a !== 1'b0) begin errors++; $display("FAIL proto_clear: got %b exp 0", eproto_a); end
    // Aborted packet: head + 2 bodies, then a fresh complete packet.
    send(8'h6C); send(8'h0D); send(8'hFD);
    send_front();
    checks++; if (eproto_a !== 1'b1) begin errors++; $display("FAIL proto_head_abort: got %b exp 1", eproto_a); end
    send(8'h82);
    checks++; if (data_a !== 32'h83FFFFFF) begin errors++; $display("FAIL proto_abort_data: got %h exp 83ffffff", data_a); end
    checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL proto_abort_count: got %0d exp 1", count_a); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    // Reserved type mid-packet leaves the state untouched.
    send(8'h6C); send(8'h0D);
    send(8'h03);
    checks++; if (eproto_a !== 1'b1) begin errors++; $display("FAIL proto_reserved: got %b exp 1", eproto_a); end
    for (int i = 0; i < 4; i++) send(8'hFD);
    send(8'h82);
    checks++; if (count_a !== 16'd2) begin errors++; $display("FAIL proto_reserved_count: got %0d exp 2", count_a); end
    checks++; if (data_a !== 32'h83FFFFFF) begin errors++; $display("FAIL proto_reserved_data: got %h exp 83ffffff", data_a); end
    // Early tail discards the packet.
    send(8'h6C); send(8'h0D); send(8'hFD); send(8'h82);
    checks++; if (count_a !== 16'd2) begin errors++; $display("FAIL proto_early_tail_count: got %0d exp 2", count_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL proto_early_tail_valid: got %b exp 0", valid_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    pkt_ready = 1'b0;
    send_front();
    send(8'h82);
    send(8'h6C); send(8'h0D); send(8'hFD); send(8'hFD);
    do_reset();
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b exp 0", valid_a); end
    checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h exp 00000000", data_a); end
    checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d exp 0", count_a); end
    pkt_ready = 1'b1;
    send(8'hFD); send(8'hFD);
    send_front();
    send(8'h82);
    checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL rmid_after_count: got %0d exp 1", count_a); end
    checks++; if (data_a !== 32'h83FFFFFF) begin errors++; $display("FAIL rmid_after_data: got %h exp 83ffffff", data_a); end
    tick();
  endtask

  initial begin
    rst = 1'b1; flit_valid = 1'b0; flit_in = 8'h00; pkt_ready = 1'b1; err_clr = 1'b0;
    test_reset();
    test_nominal();
    test_dest_mismatch();
    test_back_pressure();
    test_overflow();
    test_protocol();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
